// File: rtl/ram_responder_pkg.sv
// Shared constants for the RAM responder: bus widths, read-latency ceiling, FSM encodings.
package ram_responder_pkg;

  // Width of the byte-address and data buses driven by the MEM stage.
  localparam int unsigned RAM_ADDR_W = 32;
  localparam int unsigned RAM_DATA_W = 32;

  // Deepest read pipeline the responder is built for.
  localparam int unsigned RD_LAT_MAX = 4;

  // Init/run FSM encodings.
  localparam logic RAM_ST_INIT = 1'b0;
  localparam logic RAM_ST_RUN  = 1'b1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Fixed-latency read-response pipeline: RD_LAT capture/shift stages, then an output
// register that pulses valid and holds the last valid data between responses.
module ram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  // Shift stages; stage 0 captures on the sampling edge. Reset drops everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      dat_q[0] <= in_data_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Output register: valid strobes for one cycle, data only updates on a valid response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) begin
        out_data_q <= dat_q[RD_LAT-1];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/ram_responder.sv
// Responder end of the core's RAM port: word array with per-bit write mask, write-first
// read forwarding, fixed-latency read responses and a post-reset zero-fill sweep.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = RAM_DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_r_ena_i,
  input  logic [RAM_ADDR_W-1:0] ram_r_addr_i,
  output logic [DATA_W-1:0]     ram_r_data_o,
  output logic                  ram_r_valid_o,
  input  logic                  ram_w_ena_i,
  input  logic [RAM_ADDR_W-1:0] ram_w_addr_i,
  input  logic [DATA_W-1:0]     ram_w_data_i,
  input  logic [DATA_W-1:0]     ram_w_mask_i,
  output logic                  ram_ready_o
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic        RstState = INIT_ZERO ? RAM_ST_INIT : RAM_ST_RUN;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic              r_fire, w_fire;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-offset and high address bits do not select a word; they alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_r_addr_i[RAM_ADDR_W-1:ADDR_W+2], ram_r_addr_i[1:0],
                              ram_w_addr_i[RAM_ADDR_W-1:ADDR_W+2], ram_w_addr_i[1:0]};

  assign r_idx  = ram_r_addr_i[ADDR_W+1:2];
  assign w_idx  = ram_w_addr_i[ADDR_W+1:2];
  assign ready  = (state_q == RAM_ST_RUN);
  assign r_fire = ram_r_ena_i & ready;
  assign w_fire = ram_w_ena_i & ready;

  assign w_merged = (mem_q[w_idx] & ~ram_w_mask_i) | (ram_w_data_i & ram_w_mask_i);
  // Write-first: a same-edge write to the read index is seen by the read.
  assign rd_word  = (w_fire && (w_idx == r_idx)) ? w_merged : mem_q[r_idx];

  // Next-state for the init sweep: one word per cycle, RUN after the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RAM_ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_d = RAM_ST_RUN;
      end
    end
  end

  // FSM and sweep counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RstState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word array: zero-fill while sweeping, masked merge on accepted writes. Not reset.
  always_ff @(posedge clk) begin
    if (state_q == RAM_ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (w_fire) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (r_fire),
    .in_data_i   (rd_word),
    .out_valid_o (ram_r_valid_o),
    .out_data_o  (ram_r_data_o)
  );

  assign ram_ready_o = ready;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model of the array and read responses.
module tb_ram_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_ena;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_valid;
  logic        w_ena;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_mask;
  logic        ready;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          sweep;
  int          cycle;
  int          due_q[$];
  logic [31:0] dat_q[$];
  logic        m_valid;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  ram_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (32),
    .RD_LAT    (RD_LAT),
    .INIT_ZERO (1'b1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ram_r_ena_i   (r_ena),
    .ram_r_addr_i  (r_addr),
    .ram_r_data_o  (r_data),
    .ram_r_valid_o (r_valid),
    .ram_w_ena_i   (w_ena),
    .ram_w_addr_i  (w_addr),
    .ram_w_data_i  (w_data),
    .ram_w_mask_i  (w_mask),
    .ram_ready_o   (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    due_q.delete();
    dat_q.delete();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_ready = 1'b0;
    sweep   = 0;
  endtask

  task automatic drive(input logic re, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] wm);
    r_ena  = re;
    r_addr = ra;
    w_ena  = we;
    w_addr = wa;
    w_data = wd;
    w_mask = wm;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // One clock: advance the model by the rules for this edge, then compare all outputs.
  task automatic tick();
    int widx;
    int ridx;
    @(posedge clk);
    cycle++;
    widx = int'(w_addr[11:2]);
    ridx = int'(r_addr[11:2]);
    if (!rst) begin
      model_clear();
    end else if (!m_ready) begin
      m_mem[sweep] = 32'h0;
      sweep++;
      if (sweep == int'(DEPTH)) m_ready = 1'b1;
    end else begin
      if (w_ena) m_mem[widx] = (m_mem[widx] & ~w_mask) | (w_data & w_mask);
      if (r_ena) begin
        due_q.push_back(cycle + int'(RD_LAT));
        dat_q.push_back(m_mem[ridx]);
      end
    end
    m_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      m_valid = 1'b1;
      m_data  = dat_q.pop_front();
      void'(due_q.pop_front());
    end
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("valid", 32'(r_valid), 32'(m_valid));
    chk("data", r_data, m_data);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", 32'(r_valid), 32'h0);
    chk("rst_data", r_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ready(input bit rand_req, output int n);
    n = 0;
    while (!ready && n < 2000) begin
      if (rand_req) begin
        drive(1'($urandom), $urandom, 1'($urandom), $urandom, $urandom, $urandom);
      end
      tick();
      n++;
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] mk;
    cycle = 0;
    rst   = 1'b0;
    idle();
    model_clear();
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b1;

    // 1: sweep length and zero-filled top word.
    wait_ready(1'b0, n);
    chk("init_cycles", 32'(n), 32'd1024);
    drive(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    repeat (RD_LAT) tick();
    chk("t1_valid", 32'(r_valid), 32'h1);
    chk("t1_data", r_data, 32'h0);

    // 2: full write, then low-half masked write, read back at exact latency.
    drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h0000_1234, 32'h0000_FFFF);
    tick();
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    chk("t2_early1", 32'(r_valid), 32'h0);
    tick();
    chk("t2_early2", 32'(r_valid), 32'h0);
    tick();
    chk("t2_valid", 32'(r_valid), 32'h1);
    chk("t2_data", r_data, 32'hDEAD_1234);

    // 3: same-cycle write and read to one index.
    drive(1'b1, 32'h20, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    tick();
    idle();
    repeat (RD_LAT) tick();
    chk("t3_data", r_data, 32'hA5A5_A5A5);

    // 4: back-to-back reads, responses on consecutive cycles, then data holds.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'(i * 4), 32'(i + 1), 32'hFFFF_FFFF);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, 32'h0);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_valid", 32'(r_valid), 32'h1);
      chk("t4_data", r_data, 32'(i + 1));
    end
    tick();
    chk("t4_drop", 32'(r_valid), 32'h0);
    chk("t4_hold", r_data, 32'h3);

    // 5: aliasing of high and byte-offset address bits.
    drive(1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'h7, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    chk("t5_alias_hi", r_data, 32'h7);
    tick();
    chk("t5_alias_lo", r_data, 32'h7);

    // Random traffic over a few indices with random high/offset bits to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       mk = 32'h0;
        1:       mk = 32'hFFFF_FFFF;
        default: mk = $urandom;
      endcase
      drive(1'($urandom), $urandom & ~32'h0000_0FC0, 1'($urandom),
            $urandom & ~32'h0000_0FC0, $urandom, mk);
      tick();
    end
    idle();
    repeat (RD_LAT + 1) tick();

    // 6: reset with reads in flight, requests during re-sweep ignored, array zero after.
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    async_reset();
    wait_ready(1'b1, n);
    chk("t6_init_cycles", 32'(n), 32'd1024);
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0, 32'h0);
      tick();
    end
    idle();
    repeat (RD_LAT) tick();
    chk("t6_last_data", r_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
